uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the UART subsystem, pairing with the UART receiver chain. It accepts one parallel byte per handshake and emits a standard asynchronous frame on `TX_OUT`: a start bit, the data bits LSB first, an optional parity bit, and one stop bit. Each bit lasts `Prescale` system clocks, so the block runs on the same system clock and oversampling ratio as the receiver, with no separate baud clock.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: data bits per frame.

Ports:
- `clk`, input, 1: system clock; all logic updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `P_DATA`, input, `DATA_WIDTH`: parallel data to send.
- `Data_Valid`, input, 1: request to send `P_DATA`.
- `PAR_EN`, input, 1: 1 inserts a parity bit.
- `PAR_TYP`, input, 1: 0 selects even parity, 1 selects odd.
- `Prescale`, input, 6: clocks per bit; 0 is treated as 1.
- `TX_OUT`, output, 1: serial line, idle high.
- `busy`, output, 1: high while a frame is in progress.

## Operation

- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `TX_OUT`=1 and `busy`=0.
  - If `Data_Valid`=1 on a rising edge, the block latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale` into shadow registers and moves to START.
  - The inputs may change freely after that edge; the frame uses only the latched values.
- START: `TX_OUT`=0 for one bit period, then go to DATA.
- DATA:
  - `TX_OUT` carries shadow data bit i, with i = 0 to `DATA_WIDTH`-1, LSB first.
  - Each bit is held for one bit period.
  - After the last bit, go to PARITY if latched `PAR_EN`=1, otherwise go to STOP.
- PARITY:
  - `TX_OUT` = XOR-reduction of the latched data, XOR latched `PAR_TYP`.
  - Even parity therefore makes the total count of ones, including the parity bit, even.
  - Hold for one bit period, then go to STOP.
- STOP: `TX_OUT`=1 for one bit period, then go to IDLE.
- Bit period counter:
  - Width is 6 bits and it counts 0 to P-1, where P = max(latched `Prescale`, 1).
  - It clears on every bit transition.
  - The bit index counter is sized as clog2(`DATA_WIDTH`) bits and clears on entry to DATA.
- Handshake:
  - `Data_Valid` is sampled only in IDLE.
  - Pulses while `busy`=1 are dropped. There is no queue and no error flag.
- Outputs `TX_OUT` and `busy` are registered; neither is driven combinationally from any input.
- Reset:
  - `rst`=1 on an edge forces IDLE, `TX_OUT`=1, `busy`=0, and clears all counters and shadow registers.
  - A frame in progress is aborted immediately, with no stop bit completion.
  - Reset takes priority over `Data_Valid` in the same cycle.

## Timing

- Latency: if the accept edge is edge N, then `TX_OUT` falls and `busy` rises after edge N+1.
- Frame length: (2 + `DATA_WIDTH` + latched `PAR_EN`) × P clocks, during which `busy` stays at 1.
- End of frame:
  - `busy` drops on the same edge that ends the stop bit.
  - The block is in IDLE for at least one clock, with `TX_OUT`=1 on that clock.
  - A `Data_Valid` in that clock is accepted.
  - Back-to-back frames are therefore separated by exactly 1 clock of idle-high line when `Data_Valid` is held high.
- Bit boundaries are exact: no jitter and no rounding, because the bit period is an integer number of clocks.
- `Prescale` changes during a frame have no effect until the next accept.

## Test plan

1. **Basic frame, no parity.** `Prescale`=8, `PAR_EN`=0, `P_DATA`=0xA5, 1-cycle `Data_Valid`.
   - `TX_OUT` = 0,1,0,1,0,0,1,0,1,1, each value held for 8 clocks.
   - `busy`=1 for exactly 80 clocks.
2. **Parity.** `Prescale`=16, `P_DATA`=0x0F.
   - With `PAR_TYP`=0, the parity bit is 0; with `PAR_TYP`=1, the parity bit is 1.
   - `busy` lasts 176 clocks. Repeat with 0x07, where even parity gives a parity bit of 1.
3. **Ignored request.** During frame 0x3C, pulse `Data_Valid` with `P_DATA`=0xFF at data bit 3.
   - Frame 0x3C completes unchanged.
   - No second frame is sent, and `busy` falls at the nominal time.
4. **Back-to-back.** Hold `Data_Valid`=1 with `P_DATA`=0x55, then 0xAA.
   - Successive start bits are separated by exactly frame length + 1 clocks.
   - The gap is a single idle-high clock.
5. **Reset mid-frame.** Assert `rst` during data bit 4.
   - After the next edge: `TX_OUT`=1 and `busy`=0.
   - A new `Data_Valid` after reset is released produces a complete, correct frame.
6. **Prescale edge cases.**
   - `Prescale`=0: each bit lasts 1 clock, and a 0x81 frame with parity takes 11 clocks.
   - `Prescale`=63: each bit lasts 63 clocks.
   - Changing `Prescale` mid-frame does not alter the current frame.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter: start, data LSB first, optional parity, one stop bit
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] data_sh;
    logic                  par_en_sh;
    logic                  par_typ_sh;
    logic [5:0]            period_sh;
    logic [5:0]            bit_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic                  bit_end;

    // Last clock of the current bit period; period_sh is never 0 outside IDLE.
    assign bit_end = (bit_cnt == period_sh - 6'd1);

    // Frame sequencing: accept in IDLE, then walk START/DATA/PARITY/STOP on bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_sh    <= '0;
            par_en_sh  <= 1'b0;
            par_typ_sh <= 1'b0;
            period_sh  <= 6'd0;
            bit_cnt    <= 6'd0;
            bit_idx    <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= 6'd0;
            if (Data_Valid) begin
                data_sh    <= P_DATA;
                par_en_sh  <= PAR_EN;
                par_typ_sh <= PAR_TYP;
                period_sh  <= (Prescale == 6'd0) ? 6'd1 : Prescale;
                state      <= START;
            end
        end else if (!bit_end) begin
            bit_cnt <= bit_cnt + 6'd1;
        end else begin
            bit_cnt <= 6'd0;
            case (state)
                START: begin
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_idx == LAST_IDX) begin
                        state <= par_en_sh ? PARITY : STOP;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                PARITY:  state <= STOP;
                default: state <= IDLE;
            endcase
        end
    end

    // Registered line and busy outputs, one clock behind the state they represent.
    always_ff @(posedge clk) begin
        if (rst) begin
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
        end else begin
            busy <= (state != IDLE);
            case (state)
                START:   TX_OUT <= 1'b0;
                DATA:    TX_OUT <= data_sh[bit_idx];
                PARITY:  TX_OUT <= (^data_sh) ^ par_typ_sh;
                default: TX_OUT <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a bit-list frame model
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept edge then checks every line clock of the frame.
    // noise: 0 quiet, 1 random inputs during frame, 2 0xFF pulse mid data bit 3,
    // 3 Data_Valid held with 0xAA queued for the next frame.
    task automatic play_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] ps, input int noise);
        bit q[$];
        int p;
        int f;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = ps;
        Data_Valid = 1'b1;
        tick();
        check("accept_tx_idle", TX_OUT, 1);
        check("accept_busy_low", busy, 0);
        Data_Valid = 1'b0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pe) q.push_back((^d) ^ pt);
        q.push_back(1'b1);
        p = (ps == 0) ? 1 : int'(ps);
        f = q.size() * p;
        for (int k = 0; k < f; k++) begin
            case (noise)
                1: begin
                    P_DATA     = 8'($urandom);
                    PAR_EN     = 1'($urandom);
                    PAR_TYP    = 1'($urandom);
                    Prescale   = 6'($urandom);
                    Data_Valid = ($urandom_range(0, 3) == 0);
                end
                2: begin
                    Data_Valid = (k == 4 * p + p / 2);
                    if (Data_Valid) P_DATA = 8'hFF;
                end
                3: begin
                    Data_Valid = 1'b1;
                    P_DATA     = 8'hAA;
                end
                default: ;
            endcase
            tick();
            check("tx_bit", TX_OUT, q[k / p]);
            check("busy_frame", busy, 1);
        end
    endtask

    task automatic check_idle(input int n);
        Data_Valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_tx", TX_OUT, 1);
            check("idle_busy", busy, 0);
        end
    endtask

    task automatic reset_mid(input logic [7:0] d, input logic [5:0] ps);
        P_DATA     = d;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        Prescale   = ps;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int k = 0; k < 5 * int'(ps) + int'(ps) / 2; k++) tick();
        check("mid_busy_before_rst", busy, 1);
        rst        = 1'b1;
        Data_Valid = 1'b1;
        P_DATA     = 8'($urandom);
        tick();
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        check_idle(3);
    endtask

    initial begin
        rst        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd1;
        repeat (3) tick();
        check("reset_tx", TX_OUT, 1);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        check_idle(2);

        play_frame(8'hA5, 1'b0, 1'b0, 6'd8, 0);
        check_idle(1);

        play_frame(8'h0F, 1'b1, 1'b0, 6'd16, 0);
        check_idle(1);
        play_frame(8'h0F, 1'b1, 1'b1, 6'd16, 0);
        check_idle(1);
        play_frame(8'h07, 1'b1, 1'b0, 6'd16, 0);
        check_idle(1);

        play_frame(8'h3C, 1'b0, 1'b0, 6'd8, 2);
        check_idle(20);

        play_frame(8'h55, 1'b0, 1'b0, 6'd4, 3);
        play_frame(8'hAA, 1'b0, 1'b0, 6'd4, 0);
        check_idle(2);

        reset_mid(8'hC3, 6'd6);
        play_frame(8'h5A, 1'b1, 1'b0, 6'd6, 0);
        check_idle(1);

        play_frame(8'h81, 1'b1, 1'b0, 6'd0, 1);
        check_idle(1);
        play_frame(8'($urandom), 1'b0, 1'b1, 6'd63, 1);
        check_idle(1);

        for (int n = 0; n < 20; n++) begin
            play_frame(8'($urandom), 1'($urandom), 1'($urandom),
                       6'($urandom_range(0, 12)), 1);
            check_idle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
